// File: rtl/mips_pkg.sv
// Shared MIPS decode types: instruction codes used by the decoder and the
// cycle sequencer state, plus load/store/divide classification helpers.
package mips_pkg;

  typedef enum logic [6:0] {
    NOP = 7'd0,
    ADDU,
    SUBU,
    ADDIU,
    SLT,
    SLL,
    MULT,
    MULTU,
    DIV,
    DIVU,
    LB,
    LBU,
    LH,
    LHU,
    LW,
    LWL,
    LWR,
    SB,
    SH,
    SW,
    BEQ,
    BNE,
    J,
    JAL,
    JR
  } instcode_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC1,
    EXEC2,
    HALTED
  } seq_state_t;

  function automatic logic is_load(input logic [6:0] code);
    return code inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction

  function automatic logic is_store(input logic [6:0] code);
    return code inside {SB, SH, SW};
  endfunction

  function automatic logic is_div(input logic [6:0] code);
    return code inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: FETCH -> EXEC1 -> EXEC2, stretched by waitrequest.
// Optional feature: define DIV_STALL_EN to hold EXEC2 on DIV/DIVU until div_done.
module cycle_sequencer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  instruction_code,
  input  logic        waitrequest,
  input  logic        halt_req,
  input  logic        div_done,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic        mem_read,
  output logic        mem_write,
  output logic        stall,
  output logic        active,
  output logic [31:0] retired
);

  seq_state_t  state;
  logic [31:0] retired_q;
  logic        ld_op;
  logic        st_op;
  logic        exec1_wait;
  logic        div_hold;

  always_comb begin
    ld_op      = is_load(instruction_code);
    st_op      = is_store(instruction_code);
    exec1_wait = (ld_op || st_op) && waitrequest;
  end

`ifdef DIV_STALL_EN
  always_comb begin
    div_hold = is_div(instruction_code) && !div_done;
  end
`else
  logic unused_div_done;
  always_comb begin
    unused_div_done = div_done;
    div_hold        = 1'b0;
  end
`endif

  // Phase strobes are decoded from the state register and forced low during reset.
  always_comb begin
    fetch     = 1'b0;
    exec1     = 1'b0;
    exec2     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    active    = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          fetch    = 1'b1;
          mem_read = 1'b1;
          stall    = waitrequest;
          active   = 1'b1;
        end
        EXEC1: begin
          exec1     = 1'b1;
          mem_read  = ld_op;
          mem_write = st_op;
          stall     = exec1_wait;
          active    = 1'b1;
        end
        EXEC2: begin
          exec2  = 1'b1;
          stall  = div_hold;
          active = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      retired_q <= '0;
    end else begin
      case (state)
        FETCH: if (!waitrequest) state <= EXEC1;
        EXEC1: if (!exec1_wait) state <= EXEC2;
        EXEC2: begin
          if (!div_hold) begin
            state     <= halt_req ? HALTED : FETCH;
            retired_q <= retired_q + 32'd1;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  always_comb begin
    retired = retired_q;
  end

endmodule
